// File: rtl/sdrc_req_split_if.sv
// Request/chunk bus of the SDRAM request splitter: application request side plus r2b chunk side.
// master = requester/bank environment, slave = the splitter itself.
interface sdrc_req_split_if #(
    parameter int APP_AW = 26,
    parameter int REQ_BW = 7,
    parameter int ID_W   = 4
);
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [REQ_BW-1:0] app_req_len;
    logic              app_req_wr_n;
    logic [ID_W-1:0]   app_req_id;
    logic              app_req_dma_last;
    logic              app_req_ack;

    logic              r2b_req;
    logic [ID_W-1:0]   r2b_req_id;
    logic              r2b_start;
    logic              r2b_last;
    logic [1:0]        r2b_ba;
    logic [11:0]       r2b_raddr;
    logic [11:0]       r2b_caddr;
    logic [REQ_BW-1:0] r2b_len;
    logic              r2b_write;
    logic              r2b_dma_last;
    logic              b2r_ack;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_id, app_req_dma_last,
        input  app_req_ack,
        input  r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_ba, r2b_raddr, r2b_caddr,
        input  r2b_len, r2b_write, r2b_dma_last,
        output b2r_ack
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_id, app_req_dma_last,
        output app_req_ack,
        output r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_ba, r2b_raddr, r2b_caddr,
        output r2b_len, r2b_write, r2b_dma_last,
        input  b2r_ack
    );
endinterface

// File: rtl/sdrc_req_split.sv
// Splits one application request into page-bounded chunks for the bank FSMs.
// Optional per-chunk length cap: define SDRC_REQ_MAX_BURST_EN to add cfg_max_burst.
//   state | meaning
//   IDLE  | no request held; accepts app_req
//   ISSUE | presenting the current chunk on r2b, waiting for b2r_ack
module sdrc_req_split #(
    parameter int APP_AW = 26,
    parameter int REQ_BW = 7,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        cfg_colbits,
`ifdef SDRC_REQ_MAX_BURST_EN
    input  logic [REQ_BW-1:0] cfg_max_burst,
`endif
    sdrc_req_split_if.slave   bus
);
    localparam int LW = (REQ_BW > 12) ? REQ_BW : 12;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state, state_nxt;
    logic [APP_AW-1:0] cur_addr;
    logic [REQ_BW-1:0] remaining;
    logic              write_q;
    logic              dma_last_q;
    logic              first_q;
    logic [ID_W-1:0]   id_q;

    logic [11:0]       caddr;
    logic [1:0]        ba;
    logic [11:0]       raddr;
    logic [LW-1:0]     page_room;
    logic [LW-1:0]     rem_ext;
    logic [LW-1:0]     cap;
    logic [LW-1:0]     chunk;
    logic              last;
    logic              accept;
    logic              advance;

    always_comb begin
        caddr = '0;
        ba    = '0;
        raddr = '0;
        case (cfg_colbits)
            2'b00: begin
                caddr = {4'b0, cur_addr[7:0]};
                ba    = cur_addr[9:8];
                raddr = cur_addr[21:10];
            end
            2'b01: begin
                caddr = {3'b0, cur_addr[8:0]};
                ba    = cur_addr[10:9];
                raddr = cur_addr[22:11];
            end
            2'b10: begin
                caddr = {2'b0, cur_addr[9:0]};
                ba    = cur_addr[11:10];
                raddr = cur_addr[23:12];
            end
            default: begin
                caddr = {1'b0, cur_addr[10:0]};
                ba    = cur_addr[12:11];
                raddr = cur_addr[24:13];
            end
        endcase
    end

`ifdef SDRC_REQ_MAX_BURST_EN
    assign cap = LW'(cfg_max_burst);
`else
    assign cap = '0;
`endif

    // Chunk length depends only on registered state and static config, never on b2r_ack.
    assign page_room = LW'(12'd256 << cfg_colbits) - LW'(caddr);
    assign rem_ext   = LW'(remaining);

    always_comb begin
        chunk = (rem_ext < page_room) ? rem_ext : page_room;
        if ((cap != '0) && (cap < chunk)) begin
            chunk = cap;
        end
    end

    assign last = (chunk == rem_ext);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.app_req) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.b2r_ack) begin
                    advance = 1'b1;
                    if (last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            write_q    <= 1'b0;
            dma_last_q <= 1'b0;
            first_q    <= 1'b0;
            id_q       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cur_addr   <= bus.app_req_addr;
                remaining  <= (bus.app_req_len == '0) ? REQ_BW'(1) : bus.app_req_len;
                write_q    <= ~bus.app_req_wr_n;
                dma_last_q <= bus.app_req_dma_last;
                first_q    <= 1'b1;
                id_q       <= bus.app_req_id;
            end else if (advance) begin
                cur_addr  <= cur_addr + APP_AW'(chunk);
                remaining <= remaining - chunk[REQ_BW-1:0];
                first_q   <= 1'b0;
            end
        end
    end

    // The ack is gated with reset_n so nothing is accepted while reset is held.
    assign bus.app_req_ack = accept & reset_n;

    always_comb begin
        bus.r2b_req      = 1'b0;
        bus.r2b_req_id   = '0;
        bus.r2b_start    = 1'b0;
        bus.r2b_last     = 1'b0;
        bus.r2b_ba       = '0;
        bus.r2b_raddr    = '0;
        bus.r2b_caddr    = '0;
        bus.r2b_len      = '0;
        bus.r2b_write    = 1'b0;
        bus.r2b_dma_last = 1'b0;
        if (state == ISSUE) begin
            bus.r2b_req      = 1'b1;
            bus.r2b_req_id   = id_q;
            bus.r2b_start    = first_q;
            bus.r2b_last     = last;
            bus.r2b_ba       = ba;
            bus.r2b_raddr    = raddr;
            bus.r2b_caddr    = caddr;
            bus.r2b_len      = chunk[REQ_BW-1:0];
            bus.r2b_write    = write_q;
            bus.r2b_dma_last = last & dma_last_q;
        end
    end
endmodule

// File: tb/tb_sdrc_req_split.sv
// Testbench for sdrc_req_split: directed vector table, hand-written corner sequences,
// and random requests checked against an arithmetic chunking model.
module tb_sdrc_req_split;
    localparam int APP_AW = 26;
    localparam int REQ_BW = 7;
    localparam int ID_W   = 4;

    typedef struct packed {
        logic [1:0]        ba;
        logic [11:0]       row;
        logic [11:0]       col;
        logic [REQ_BW-1:0] len;
        logic              start;
        logic              last;
        logic              write;
        logic              dmal;
        logic [ID_W-1:0]   id;
    } chunk_t;

    typedef struct {
        bit          new_req;
        int          colbits;
        logic [25:0] addr;
        int          len;
        bit          wr_n;
        bit          dmal;
        logic [3:0]  id;
        int          cap;
        chunk_t      exp;
    } tvec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] cfg_colbits;
`ifdef SDRC_REQ_MAX_BURST_EN
    logic [REQ_BW-1:0] cfg_max_burst;
`endif

    int comps = 0;
    int fails = 0;
    chunk_t exp_q[$];
    tvec_t  tv[$];

    sdrc_req_split_if #(.APP_AW(APP_AW), .REQ_BW(REQ_BW), .ID_W(ID_W)) bus ();

    sdrc_req_split #(.APP_AW(APP_AW), .REQ_BW(REQ_BW), .ID_W(ID_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_colbits (cfg_colbits),
`ifdef SDRC_REQ_MAX_BURST_EN
        .cfg_max_burst (cfg_max_burst),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        comps++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic chunk_t act_chunk();
        chunk_t a;
        a.ba    = bus.r2b_ba;
        a.row   = bus.r2b_raddr;
        a.col   = bus.r2b_caddr;
        a.len   = bus.r2b_len;
        a.start = bus.r2b_start;
        a.last  = bus.r2b_last;
        a.write = bus.r2b_write;
        a.dmal  = bus.r2b_dma_last;
        a.id    = bus.r2b_req_id;
        return a;
    endfunction

    // Reference: walk the request page by page with plain arithmetic.
    function automatic void model(input logic [25:0] addr, input int len, input bit wr_n,
                                  input logic [3:0] id, input bit dmal, input int colbits,
                                  input int cap);
        longint a;
        int     rem, c, page, col, n;
        bit     first;
        chunk_t e;
        a     = addr;
        rem   = (len == 0) ? 1 : len;
        c     = 8 + colbits;
        page  = 1 << c;
        first = 1;
        while (rem > 0) begin
            col = int'(a % page);
            n   = rem;
            if (page - col < n) n = page - col;
            if (cap != 0 && cap < n) n = cap;
            e.ba    = 2'((a >> c) % 4);
            e.row   = 12'((a >> (c + 2)) % 4096);
            e.col   = 12'(col);
            e.len   = REQ_BW'(n);
            e.start = first;
            e.last  = (n == rem);
            e.write = !wr_n;
            e.dmal  = dmal && (n == rem);
            e.id    = id;
            exp_q.push_back(e);
            a     = (a + n) % (64'd1 << APP_AW);
            rem   = rem - n;
            first = 0;
        end
    endfunction

    function automatic tvec_t mk(input bit nr, input int cb, input logic [25:0] a, input int l,
                                 input bit wn, input bit dl, input logic [3:0] id, input int cap,
                                 input logic [1:0] ba, input int row, input int col,
                                 input int clen, input bit st, input bit la);
        tvec_t t;
        t.new_req   = nr;
        t.colbits   = cb;
        t.addr      = a;
        t.len       = l;
        t.wr_n      = wn;
        t.dmal      = dl;
        t.id        = id;
        t.cap       = cap;
        t.exp.ba    = ba;
        t.exp.row   = 12'(row);
        t.exp.col   = 12'(col);
        t.exp.len   = REQ_BW'(clen);
        t.exp.start = st;
        t.exp.last  = la;
        t.exp.write = !wn;
        t.exp.dmal  = dl && la;
        t.exp.id    = id;
        return t;
    endfunction

    // Presents a request and waits for its ack; returns one negedge after the accept edge.
    task automatic send_req(input int colbits, input logic [25:0] addr, input int len,
                            input bit wr_n, input logic [3:0] id, input bit dmal, input int cap);
        int n = 0;
        @(negedge clk);
        cfg_colbits          = 2'(colbits);
`ifdef SDRC_REQ_MAX_BURST_EN
        cfg_max_burst        = REQ_BW'(cap);
`endif
        bus.app_req          = 1'b1;
        bus.app_req_addr     = addr;
        bus.app_req_len      = REQ_BW'(len);
        bus.app_req_wr_n     = wr_n;
        bus.app_req_id       = id;
        bus.app_req_dma_last = dmal;
        #1;
        while (!bus.app_req_ack && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.app_req_ack) begin
            chk("ack_timeout", bus.app_req_ack, 1);
        end else begin
            chk("req_low_at_ack", bus.r2b_req, 0);
        end
        @(negedge clk);
        bus.app_req = 1'b0;
        chk("req_latency", bus.r2b_req, 1);
    endtask

    task automatic take_chunk(input chunk_t e, input int stall, input string name);
        int n = 0;
        chunk_t snap;
        while (!bus.r2b_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.r2b_req) begin
            chk({name, "_timeout"}, bus.r2b_req, 1);
            return;
        end
        chk(name, act_chunk(), e);
        snap = act_chunk();
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_stable"}, {bus.r2b_req, act_chunk()}, {1'b1, snap});
        end
        bus.b2r_ack = 1'b1;
        @(negedge clk);
        bus.b2r_ack = 1'b0;
    endtask

    task automatic drain(input int maxstall, input string name);
        chunk_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            take_chunk(e, $urandom_range(0, maxstall), name);
        end
        chk({name, "_no_extra"}, bus.r2b_req, 0);
    endtask

    initial begin
        chunk_t      snap, e;
        logic [25:0] a;
        int          cb, len, cap;
        logic [25:0] mask;

        reset_n              = 1'b0;
        cfg_colbits          = 2'b00;
`ifdef SDRC_REQ_MAX_BURST_EN
        cfg_max_burst        = '0;
`endif
        bus.app_req          = 1'b0;
        bus.app_req_addr     = '0;
        bus.app_req_len      = '0;
        bus.app_req_wr_n     = 1'b1;
        bus.app_req_id       = '0;
        bus.app_req_dma_last = 1'b0;
        bus.b2r_ack          = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.r2b_req, bus.app_req_ack, act_chunk()}, '0);
        reset_n = 1'b1;

        // Directed vectors: page split, single chunk, dma_last, len 0, page-edge starts, row carry.
        tv.push_back(mk(1, 0, 26'h00000F0, 32, 0, 0, 4'd1, 0, 2'd0, 0, 'h0F0, 16, 1, 0));
        tv.push_back(mk(0, 0, 26'h00000F0, 32, 0, 0, 4'd1, 0, 2'd1, 0, 'h000, 16, 0, 1));
        tv.push_back(mk(1, 1, 26'h0000200,  8, 1, 0, 4'd2, 0, 2'd1, 0, 'h000,  8, 1, 1));
        tv.push_back(mk(1, 0, 26'h00000F0, 32, 0, 1, 4'd3, 0, 2'd0, 0, 'h0F0, 16, 1, 0));
        tv.push_back(mk(0, 0, 26'h00000F0, 32, 0, 1, 4'd3, 0, 2'd1, 0, 'h000, 16, 0, 1));
        tv.push_back(mk(1, 0, 26'h00003FF,  0, 1, 1, 4'd4, 0, 2'd3, 0, 'h0FF,  1, 1, 1));
        tv.push_back(mk(1, 3, 26'h00007FF,  5, 0, 0, 4'd5, 0, 2'd0, 0, 'h7FF,  1, 1, 0));
        tv.push_back(mk(0, 3, 26'h00007FF,  5, 0, 0, 4'd5, 0, 2'd1, 0, 'h000,  4, 0, 1));
        tv.push_back(mk(1, 2, 26'h00003F0, 16, 0, 0, 4'd6, 0, 2'd0, 0, 'h3F0, 16, 1, 1));
        tv.push_back(mk(1, 0, 26'h00003FC,  8, 1, 0, 4'd7, 0, 2'd3, 0, 'h0FC,  4, 1, 0));
        tv.push_back(mk(0, 0, 26'h00003FC,  8, 1, 0, 4'd7, 0, 2'd0, 1, 'h000,  4, 0, 1));
`ifdef SDRC_REQ_MAX_BURST_EN
        tv.push_back(mk(1, 0, 26'h0000000, 20, 0, 0, 4'd8, 8, 2'd0, 0, 'h000,  8, 1, 0));
        tv.push_back(mk(0, 0, 26'h0000000, 20, 0, 0, 4'd8, 8, 2'd0, 0, 'h008,  8, 0, 0));
        tv.push_back(mk(0, 0, 26'h0000000, 20, 0, 0, 4'd8, 8, 2'd0, 0, 'h010,  4, 0, 1));
`endif
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].new_req)
                send_req(tv[i].colbits, tv[i].addr, tv[i].len, tv[i].wr_n, tv[i].id,
                         tv[i].dmal, tv[i].cap);
            take_chunk(tv[i].exp, 0, "vec");
            if (tv[i].exp.last) chk("vec_no_extra", bus.r2b_req, 0);
        end

        // Backpressure with a competing request raised during the stall.
        model(26'h00000F0, 32, 0, 4'd1, 0, 0, 0);
        send_req(0, 26'h00000F0, 32, 0, 4'd1, 0, 0);
        e = exp_q.pop_front();
        chk("bp_chunk1", act_chunk(), e);
        snap                 = act_chunk();
        bus.app_req          = 1'b1;
        bus.app_req_addr     = 26'h0001234;
        bus.app_req_len      = REQ_BW'(3);
        bus.app_req_wr_n     = 1'b1;
        bus.app_req_id       = 4'd9;
        bus.app_req_dma_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_stable", {bus.r2b_req, act_chunk()}, {1'b1, snap});
            chk("bp_no_ack", bus.app_req_ack, 0);
        end
        bus.b2r_ack = 1'b1;
        @(negedge clk);
        bus.b2r_ack = 1'b0;
        #1;
        e = exp_q.pop_front();
        chk("bp_chunk2", {bus.r2b_req, act_chunk()}, {1'b1, e});
        chk("bp_no_ack2", bus.app_req_ack, 0);
        bus.b2r_ack = 1'b1;
        @(negedge clk);
        bus.b2r_ack = 1'b0;
        #1;
        chk("bp_ack_after_idle", {bus.app_req_ack, bus.r2b_req}, 2'b10);
        @(negedge clk);
        bus.app_req = 1'b0;
        model(26'h0001234, 3, 1, 4'd9, 0, 0, 0);
        drain(0, "bp_second");

        // Reset after the first chunk is acked drops the rest of the request.
        model(26'h00000F0, 32, 0, 4'd1, 0, 0, 0);
        send_req(0, 26'h00000F0, 32, 0, 4'd1, 0, 0);
        e = exp_q.pop_front();
        take_chunk(e, 0, "rst_chunk1");
        exp_q.delete();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {bus.r2b_req, bus.app_req_ack, act_chunk()}, '0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", bus.r2b_req, 0);
        model(26'h0000040, 4, 0, 4'd2, 0, 0, 0);
        send_req(0, 26'h0000040, 4, 0, 4'd2, 0, 0);
        drain(0, "rst_reissue");

        // Random requests against the model.
        for (int r = 0; r < 40; r++) begin
            cb   = $urandom_range(0, 3);
            a    = 26'($urandom);
            mask = 26'((1 << (8 + cb)) - 1);
            if ($urandom_range(0, 3) == 0) a = (a & ~mask) | (mask - 26'($urandom_range(0, 2)));
            if ($urandom_range(0, 9) == 0) a = 26'h3FFFFFF - 26'($urandom_range(0, 40));
            len = $urandom_range(0, 127);
`ifdef SDRC_REQ_MAX_BURST_EN
            cap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
`else
            cap = 0;
`endif
            model(a, len, bit'($urandom_range(0, 1)), 4'(r), bit'($urandom_range(0, 1)), cb, cap);
            e = exp_q[0];
            send_req(cb, a, len, !e.write, e.id, exp_q[exp_q.size() - 1].dmal, cap);
            drain(2, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end
endmodule

// File: doc/sdrc_req_split.md
Name: sdrc_req_split

Overview:
Upstream stage of the per-bank FSMs. Accepts one application transfer request (word address, length, direction, ID) and splits it into bank-sized chunks that never cross an SDRAM column-page boundary. Decodes each chunk into bank/row/column. Presents each chunk on the r2b request interface with start/last flags and waits for the bank FSM's b2r_ack before issuing the next chunk.

Parameters:
APP_AW, 26, application word-address width; must be >= 25.
REQ_BW, 7, length width in SDR words.
ID_W, 4, request ID width.

Ports:
clk  in  1  clock
reset_n  in  1  reset
app_req  in  1  request valid; held by the requester until app_req_ack
app_req_addr  in  APP_AW  start word address
app_req_len  in  REQ_BW  length in words; 0 is illegal and is treated as 1
app_req_wr_n  in  1  0 = write, 1 = read
app_req_id  in  ID_W  transfer ID
app_req_dma_last  in  1  final request of a DMA sequence
app_req_ack  out  1  one-cycle accept pulse
cfg_colbits  in  2  column width: 00 = 8, 01 = 9, 10 = 10, 11 = 11 bits
r2b_req  out  1  chunk valid
r2b_req_id  out  ID_W  ID of the chunk
r2b_start  out  1  first chunk of the request
r2b_last  out  1  last chunk of the request
r2b_ba  out  2  bank select
r2b_raddr  out  12  row address
r2b_caddr  out  12  column address, zero-extended
r2b_len  out  REQ_BW  chunk length in words
r2b_write  out  1  write chunk
r2b_dma_last  out  1  equals r2b_last AND the latched dma_last
b2r_ack  in  1  chunk accepted; sampled only while r2b_req = 1

Behaviour:
- Reset: reset_n is synchronous, active-low, on clk. All outputs 0. FSM enters IDLE. Internal registers cleared.
- Reset mid-operation: the in-flight request is dropped with no further r2b_req. The requester must re-issue it.
- Address decode, with C = 8 + cfg_colbits, applied to the current address cur_addr:
  - caddr = cur_addr[C-1:0]
  - ba = cur_addr[C+1:C]
  - raddr = cur_addr[C+13:C+2]
- cfg_colbits is quasi-static and may change only while in IDLE.
- Chunk length: chunk = min(remaining, 2^C - caddr). This value is combinational from registered state only. There is no combinational path from b2r_ack to any r2b output.
- FSM states: IDLE, ISSUE.
  - IDLE: r2b_req = 0. On app_req = 1:
    - pulse app_req_ack in the same cycle;
    - latch addr, len (0 becomes 1), write = ~app_req_wr_n, id, dma_last;
    - set first = 1;
    - next state ISSUE.
  - ISSUE: r2b_req = 1.
    - r2b_start = first.
    - r2b_last = (chunk == remaining).
    - All r2b fields are held stable until b2r_ack.
    - On b2r_ack:
      - cur_addr += chunk, modulo 2^APP_AW (wraps at the top of the address space);
      - remaining -= chunk;
      - first = 0;
      - if r2b_last was 1, go to IDLE; otherwise stay in ISSUE.
- Latency:
  - app_req accepted at edge N gives r2b_req = 1 from cycle N+1.
  - After the last ack, at least one IDLE cycle passes before the next app_req_ack. A single chunk is therefore acked at the earliest 1 cycle after accept.
- app_req asserted while in ISSUE is not acked and has no effect.
- A request that ends exactly at a page end produces no zero-length chunk.
- A request that starts at caddr = 2^C - 1 produces a first chunk of length 1.
- Bank/row change across a split follows the decode rule; the row increments when the bank bits wrap.

Optional Feature:
Macro SDRC_REQ_MAX_BURST_EN.
- Defined: adds input port cfg_max_burst [REQ_BW-1:0].
  - chunk = min(remaining, 2^C - caddr, cfg_max_burst).
  - cfg_max_burst = 0 means no cap.
- Undefined: the port does not exist and chunks are limited only by the page boundary.

Test Plan:
1. Page split, cfg_colbits = 00, addr 0x00000F0, len 32, write.
   -> chunk1: ba 0, row 0, caddr 0x0F0, len 16, start 1, last 0, write 1.
   -> chunk2: ba 1, row 0, caddr 0x000, len 16, start 0, last 1.
2. Single chunk, cfg_colbits = 01, addr 0x0000200, len 8, read.
   -> one chunk: ba 1, row 0, caddr 0, len 8, start 1, last 1.
   -> r2b_req rises 1 cycle after app_req_ack.
3. Backpressure: case 1 with b2r_ack held low for 5 cycles on chunk1.
   -> all r2b outputs stable for 5 cycles.
   -> chunk2 appears the cycle after the ack.
   -> a second app_req raised meanwhile is not acked until 1 cycle after the last ack.
4. Reset mid-request: assert reset_n = 0 after chunk1 ack in case 1.
   -> next cycle all outputs 0 and the state is IDLE.
   -> a new request after reset starts with r2b_start = 1.
5. dma_last: case 1 with app_req_dma_last = 1.
   -> r2b_dma_last = 0 on chunk1 and 1 on chunk2.
   -> len 0 request gives one chunk of len 1.
6. SDRC_REQ_MAX_BURST_EN defined, cfg_max_burst 8, addr 0x0000000, len 20.
   -> chunks len 8, 8, 4 at caddr 0x000, 0x008, 0x010.
   -> last = 1 on the third chunk only.
